// File: rtl/psx_pkg.sv
// psx_pkg: shared state encoding, protocol constants and response helper for the PSX pad responder.
// PSX_PAD_ANALOG_EN selects the analog pad frame (ID 0x73, 9 bytes, sticks latched with buttons).
package psx_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_RX, ST_ACK_WAIT, ST_ACK_PULSE, ST_IGNORE, ST_DONE} state_t;
  localparam logic [7:0] PSX_CMD_START = 8'h01;
  localparam logic [7:0] PSX_CMD_POLL = 8'h42;
  localparam logic [7:0] PSX_ID_DIGITAL = 8'h41;
  localparam logic [7:0] PSX_ID_ANALOG = 8'h73;
  localparam logic [7:0] PSX_DATA_MARK = 8'h5A;
`ifdef PSX_PAD_ANALOG_EN
  localparam int FRAME_W = 48;
  localparam logic [3:0] LAST_BYTE = 4'd8;
  localparam logic [7:0] PSX_ID = PSX_ID_ANALOG;
`else
  localparam int FRAME_W = 16;
  localparam logic [3:0] LAST_BYTE = 4'd4;
  localparam logic [7:0] PSX_ID = PSX_ID_DIGITAL;
`endif
  // Byte the pad returns at position idx; bytes 3 and up come from the latched frame.
  function automatic logic [7:0] resp_byte(input logic [3:0] idx, input logic [FRAME_W-1:0] frame);
    logic [FRAME_W-1:0] sh;
    sh = frame >> {idx - 4'd3, 3'b000};
    return idx == 4'd0 ? 8'hFF : idx == 4'd1 ? PSX_ID : idx == 4'd2 ? PSX_DATA_MARK : sh[7:0];
  endfunction
endpackage

// File: rtl/psx_pad_responder_if.sv
// psx_pad_responder_if: PSX controller bus between the host (master) and the pad (slave).
interface psx_pad_responder_if;
  logic psx_clk;
  logic cmd;
  logic att;
  logic dat;
  logic ack;
  modport master (output psx_clk, cmd, att, input dat, ack);
  modport slave (input psx_clk, cmd, att, output dat, ack);
endinterface

// File: rtl/psx_sync.sv
// psx_sync: 2-flop synchronizer on the falling clk edge with rise/fall strobes from a third history flop.
module psx_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic meta, sync, prev;
  // Two stages for metastability, one more to detect edges on the settled value.
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) {meta, sync, prev} <= {3{RST_VAL}};
    else {meta, sync, prev} <= {d, meta, sync};
  assign q = sync;
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;
endmodule

// File: rtl/psx_pad_responder.sv
// psx_pad_responder: device-side PlayStation pad emulation answering the 0x01 0x42 poll.
// Define PSX_PAD_ANALOG_EN for the analog pad (extra sticks input, 9-byte frame).
module psx_pad_responder
  import psx_pkg::*;
#(
  parameter int ACK_DELAY = 6,
  parameter int ACK_WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  psx_pad_responder_if.slave  bus,
  input  logic [15:0]         buttons,
`ifdef PSX_PAD_ANALOG_EN
  input  logic [31:0]         sticks,
`endif
  output logic                poll_done
);
  state_t state, state_n;
  logic dat, dat_n, ack, ack_n, done_n;
  logic [7:0] cnt, cnt_n;
  logic [2:0] bit_idx, bit_n;
  logic [3:0] byte_idx, byte_n;
  logic [6:0] rx, rx_n;
  logic [FRAME_W-1:0] frame, frame_n, frame_in;
  logic [7:0] rx_byte, resp_cur, resp_nxt;
  logic pclk_rise, pclk_fall, cmd_q, att_rise, att_fall;
  logic pclk_q, cmd_rise, cmd_fall, att_q;
  logic unused_sync;
  logic bad;

  psx_sync #(.RST_VAL(1'b1)) u_sync_clk (.clk(clk), .rst_n(rst_n), .d(bus.psx_clk), .q(pclk_q), .rise(pclk_rise), .fall(pclk_fall));
  psx_sync #(.RST_VAL(1'b1)) u_sync_cmd (.clk(clk), .rst_n(rst_n), .d(bus.cmd), .q(cmd_q), .rise(cmd_rise), .fall(cmd_fall));
  psx_sync #(.RST_VAL(1'b1)) u_sync_att (.clk(clk), .rst_n(rst_n), .d(bus.att), .q(att_q), .rise(att_rise), .fall(att_fall));
  assign unused_sync = &{1'b0, pclk_q, cmd_rise, cmd_fall, att_q};

`ifdef PSX_PAD_ANALOG_EN
  assign frame_in = {sticks, buttons};
`else
  assign frame_in = buttons;
`endif
  assign rx_byte = {cmd_q, rx};
  assign resp_cur = resp_byte(byte_idx, frame);
  assign resp_nxt = resp_byte(byte_idx + 4'd1, frame);
  assign bad = (byte_idx == 4'd0 && rx_byte != PSX_CMD_START) || (byte_idx == 4'd1 && rx_byte != PSX_CMD_POLL);
  assign bus.dat = dat;
  assign bus.ack = ack;

  // State and datapath registers; reset puts the bus lines idle.
  always_ff @(negedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      dat <= 1'b1;
      ack <= 1'b1;
      poll_done <= 1'b0;
      cnt <= '0;
      bit_idx <= '0;
      byte_idx <= '0;
      rx <= '0;
      frame <= '0;
    end else begin
      state <= state_n;
      dat <= dat_n;
      ack <= ack_n;
      poll_done <= done_n;
      cnt <= cnt_n;
      bit_idx <= bit_n;
      byte_idx <= byte_n;
      rx <= rx_n;
      frame <= frame_n;
    end

  // Next-state logic: attention release overrides everything, a new psx_clk fall cancels a pending ack.
  always_comb begin
    state_n = state;
    dat_n = dat;
    ack_n = ack;
    done_n = 1'b0;
    cnt_n = cnt;
    bit_n = bit_idx;
    byte_n = byte_idx;
    rx_n = rx;
    frame_n = frame;
    if (att_rise) begin
      state_n = ST_IDLE;
      dat_n = 1'b1;
      ack_n = 1'b1;
      cnt_n = '0;
      bit_n = '0;
      byte_n = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          dat_n = 1'b1;
          ack_n = 1'b1;
          if (att_fall) begin
            frame_n = frame_in;
            bit_n = '0;
            byte_n = '0;
            state_n = ST_RX;
          end
        end
        ST_RX: begin
          if (pclk_fall) dat_n = resp_cur[bit_idx];
          if (pclk_rise) begin
            rx_n = rx_byte[7:1];
            bit_n = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              cnt_n = '0;
              done_n = !bad && byte_idx == LAST_BYTE;
              state_n = bad ? ST_IGNORE : byte_idx == LAST_BYTE ? ST_DONE : ST_ACK_WAIT;
            end
          end
        end
        ST_ACK_WAIT, ST_ACK_PULSE: begin
          if (pclk_fall) begin
            ack_n = 1'b1;
            byte_n = byte_idx + 4'd1;
            dat_n = resp_nxt[bit_idx];
            cnt_n = '0;
            state_n = ST_RX;
          end else if (state == ST_ACK_WAIT && cnt == 8'(ACK_DELAY - 1)) begin
            ack_n = 1'b0;
            cnt_n = '0;
            state_n = ST_ACK_PULSE;
          end else if (state == ST_ACK_PULSE && cnt == 8'(ACK_WIDTH - 1)) begin
            ack_n = 1'b1;
            cnt_n = '0;
            byte_n = byte_idx + 4'd1;
            state_n = ST_RX;
          end else cnt_n = cnt + 8'd1;
        end
        default: begin
          dat_n = 1'b1;
          ack_n = 1'b1;
        end
      endcase
    end
  end
endmodule
